// File: rtl/avg_slicer_pkg.sv
// Shared types and widths for the IQ averager bit slicer.
package avg_slicer_pkg;
  typedef enum logic [0:0] {HUNT = 1'b0, DATA = 1'b1} state_t;

  localparam logic [15:0] SYNC_WORD_DEF = 16'h2DD4;
  localparam int AVG_W  = 32;
  localparam int SYNC_W = 16;
  localparam int ERAS_W = 16;
endpackage

// File: rtl/byte_fifo2.sv
// Two-entry 8-bit valid/ready buffer between the slicer and the processor side.
// Latency: a pushed byte is visible at dout one cycle after the push.
// Backpressure: a push while full without a same-cycle pop is dropped and flagged.
module byte_fifo2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_dat,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       valid,
  output logic       full,
  output logic       drop
);
  logic [7:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_pop;
  logic       do_push;

  assign valid   = (count != 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && valid;
  // A pop frees the slot the write pointer already points at, so full+pop still accepts.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= 8'd0;
      mem[1] <= 8'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/avg_bit_slicer.sv
// Slices averaged amplitudes to bits with hysteresis, hunts sync in either polarity, packs bytes.
// Latency: sync_found one cycle after the last sync bit; byte_valid one cycle after a byte's 8th bit.
// Backpressure: none upstream; 2-entry output buffer drops bytes when full and sets overflow.
module avg_bit_slicer
  import avg_slicer_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD   = SYNC_WORD_DEF,
  parameter int          FRAME_BYTES = 8,
  parameter int          HYST        = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AVG_W-1:0]  average,
  input  logic              avg_valid,
  input  logic              hunt,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              sync_found,
  output logic              inverted,
  output logic              frame_active,
  output logic              frame_done,
  output logic              overflow,
  output logic [ERAS_W-1:0] erasures
);
  localparam logic signed [AVG_W-1:0] THR_HI    = HYST;
  localparam logic signed [AVG_W-1:0] THR_LO    = -HYST;
  localparam logic [7:0]              LAST_BYTE = 8'(FRAME_BYTES - 1);

  state_t            state;
  logic [SYNC_W-1:0] shreg;
  logic [SYNC_W-1:0] shreg_nxt;
  logic              prev_raw;
  logic              raw;
  logic              dead;
  logic              dbit;
  logic [2:0]        bit_cnt;
  logic [7:0]        byte_cnt;
  logic [7:0]        asm_q;
  logic [7:0]        asm_nxt;
  logic              sync_pos;
  logic              sync_neg;
  logic              last_bit;
  logic              push;
  logic              fifo_full;
  logic              fifo_drop;

  // Inside the dead-band the previous decision is held rather than guessed.
  always_comb begin
    raw  = prev_raw;
    dead = 1'b0;
    if ($signed(average) > THR_HI) begin
      raw = 1'b1;
    end else if ($signed(average) < THR_LO) begin
      raw = 1'b0;
    end else begin
      dead = 1'b1;
    end
  end

  assign dbit         = raw ^ inverted;
  assign shreg_nxt    = {shreg[SYNC_W-2:0], raw};
  assign sync_pos     = (shreg_nxt == SYNC_WORD);
  assign sync_neg     = (shreg_nxt == ~SYNC_WORD);
  assign asm_nxt      = {asm_q[6:0], dbit};
  assign last_bit     = (bit_cnt == 3'd7);
  assign push         = avg_valid && !hunt && (state == DATA) && last_bit;
  assign frame_active = (state == DATA);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= HUNT;
      shreg      <= '0;
      prev_raw   <= 1'b0;
      inverted   <= 1'b0;
      bit_cnt    <= 3'd0;
      byte_cnt   <= 8'd0;
      asm_q      <= 8'd0;
      sync_found <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      erasures   <= '0;
    end else begin
      sync_found <= 1'b0;
      frame_done <= 1'b0;
      if (fifo_drop) begin
        overflow <= 1'b1;
      end
      if (hunt) begin
        state    <= HUNT;
        shreg    <= '0;
        bit_cnt  <= 3'd0;
        byte_cnt <= 8'd0;
        overflow <= 1'b0;
        erasures <= '0;
        inverted <= 1'b0;
      end else if (avg_valid) begin
        prev_raw <= raw;
        if (dead && (erasures != '1)) begin
          erasures <= erasures + 1'b1;
        end
        if (state == HUNT) begin
          shreg <= shreg_nxt;
          if (sync_pos || sync_neg) begin
            state      <= DATA;
            inverted   <= sync_neg;
            sync_found <= 1'b1;
            erasures   <= '0;
            bit_cnt    <= 3'd0;
            byte_cnt   <= 8'd0;
          end
        end else begin
          asm_q   <= asm_nxt;
          bit_cnt <= bit_cnt + 3'd1;
          // A dropped byte still counts, so frame boundaries survive overflow.
          if (last_bit) begin
            if (byte_cnt == LAST_BYTE) begin
              frame_done <= 1'b1;
              state      <= HUNT;
              shreg      <= '0;
              byte_cnt   <= 8'd0;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    assert (!fifo_drop || fifo_full);
  end

  byte_fifo2 u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (asm_nxt),
    .pop      (byte_ready),
    .dout     (byte_out),
    .valid    (byte_valid),
    .full     (fifo_full),
    .drop     (fifo_drop)
  );
endmodule

// File: tb/tb_avg_bit_slicer.sv
// Scoreboard bench: behavioural model predicts flags and bytes; a monitor compares on handshakes.
module tb_avg_bit_slicer;
  localparam logic [15:0] SYNC = 16'h2DD4;
  localparam int FB   = 8;
  localparam int HYST = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] average = 32'd0;
  logic        avg_valid = 1'b0;
  logic        hunt = 1'b0;
  logic        byte_ready = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        sync_found;
  logic        inverted;
  logic        frame_active;
  logic        frame_done;
  logic        overflow;
  logic [15:0] erasures;

  avg_bit_slicer #(.SYNC_WORD(SYNC), .FRAME_BYTES(FB), .HYST(HYST)) dut (
    .clk          (clk),
    .rst          (rst),
    .average      (average),
    .avg_valid    (avg_valid),
    .hunt         (hunt),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .sync_found   (sync_found),
    .inverted     (inverted),
    .frame_active (frame_active),
    .frame_done   (frame_done),
    .overflow     (overflow),
    .erasures     (erasures)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  exp_bytes[$];
  logic [21:0] exp_flags[$];
  logic [21:0] mon_e;

  // Reference model state: frame phase, recent raw bits, buffer occupancy.
  bit          m_data, m_inv, m_prev, m_ovf, rdy;
  logic [15:0] m_win;
  logic [7:0]  m_cur;
  int          m_bits, m_bytes, m_occ, m_eras;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data = 0; m_inv = 0; m_prev = 0; m_ovf = 0;
    m_win = 16'd0; m_cur = 8'd0;
    m_bits = 0; m_bytes = 0; m_occ = 0; m_eras = 0;
    exp_bytes.delete();
    exp_flags.delete();
  endtask

  // One clock of stimulus; the model predicts what the outputs show after the next edge.
  task automatic cyc(input bit v, input int amp, input bit h);
    int pop, pushed;
    bit sf, fd, raw;
    @(posedge clk);
    #2;
    avg_valid = v; average = amp; hunt = h; byte_ready = rdy;
    pop = (m_occ > 0 && rdy) ? 1 : 0;
    pushed = 0; sf = 0; fd = 0;
    if (h) begin
      m_data = 0; m_win = 16'd0; m_bits = 0; m_bytes = 0;
      m_ovf = 0; m_eras = 0; m_inv = 0;
    end else if (v) begin
      if (amp > HYST) raw = 1;
      else if (amp < -HYST) raw = 0;
      else begin
        raw = m_prev;
        if (m_eras < 65535) m_eras++;
      end
      m_prev = raw;
      if (!m_data) begin
        m_win = {m_win[14:0], raw};
        if (m_win == SYNC || m_win == ~SYNC) begin
          m_data = 1; m_inv = (m_win != SYNC); sf = 1; m_eras = 0;
          m_bits = 0; m_bytes = 0;
        end
      end else begin
        m_cur = {m_cur[6:0], raw ^ m_inv};
        m_bits++;
        if (m_bits == 8) begin
          m_bits = 0;
          m_bytes++;
          if (m_occ < 2 || pop != 0) begin
            exp_bytes.push_back(m_cur);
            pushed = 1;
          end else begin
            m_ovf = 1;
          end
          if (m_bytes == FB) begin
            fd = 1; m_data = 0; m_win = 16'd0; m_bytes = 0;
          end
        end
      end
    end
    m_occ = m_occ - pop + pushed;
    exp_flags.push_back({m_occ > 0, sf, fd, m_inv, m_data, m_ovf, m_eras[15:0]});
  endtask

  task automatic send_bit(input bit b);
    cyc(1'b1, b ? 1080 : -1900, 1'b0);
  endtask

  task automatic send_word(input logic [15:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 0, 1'b0);
  endtask

  function automatic int amp_for(input bit b);
    int a;
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) a = int'($urandom_range(0, 2 * HYST)) - HYST;
    else if (r == 1) a = HYST;
    else if (r == 2) a = -HYST;
    else if (r == 3) a = b ? HYST + 1 : -HYST - 1;
    else if (r == 4) a = b ? 32'sh7FFFFFFF : 32'sh80000000;
    else begin
      a = int'($urandom_range(HYST + 1, 5000));
      if (!b) a = -a;
    end
    return a;
  endfunction

  task automatic rand_bit(input bit b, input bit clean);
    rdy = ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 3) == 0) cyc(1'b0, int'($urandom), 1'b0);
    cyc(1'b1, clean ? (b ? 1080 : -1900) : amp_for(b), ($urandom_range(0, 299) == 0));
  endtask

  // Monitor: flags just after each edge, byte handshakes mid-cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_flags.size() > 0) begin
        mon_e = exp_flags.pop_front();
        check("flags", {10'd0, byte_valid, sync_found, frame_done, inverted,
                        frame_active, overflow, erasures}, {10'd0, mon_e});
      end
      @(negedge clk);
      if (byte_valid && byte_ready) begin
        if (exp_bytes.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL byte: got unexpected %h expected none at %0t", byte_out, $time);
        end else begin
          check("byte", {24'd0, byte_out}, {24'd0, exp_bytes.pop_front()});
        end
      end
    end
  end

  initial begin
    model_reset();
    rdy = 0;
    #1 rst = 1'b0;
    #2;
    check("reset_outs", {2'd0, byte_out, byte_valid, sync_found, inverted, frame_active,
                         frame_done, overflow, erasures}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    // Normal frame
    rdy = 1;
    send_word(SYNC, 16);
    send_word(16'hA5, 8);
    send_word(16'h3C, 8);
    for (int i = 0; i < 6; i++) send_word(16'($urandom_range(0, 255)), 8);
    idle(4);

    // Inverted sync: raw 5A decodes to A5
    send_word(~SYNC, 16);
    send_word(16'h5A, 8);
    cyc(1'b0, 0, 1'b1);
    idle(3);

    // Dead-band samples right after sync
    send_word(SYNC, 16);
    cyc(1'b1, 1080, 1'b0);
    cyc(1'b1, 100, 1'b0);
    cyc(1'b1, -100, 1'b0);
    cyc(1'b1, -1960, 1'b0);
    send_word(16'h9, 4);
    cyc(1'b0, 0, 1'b1);
    idle(3);

    // Backpressure: three bytes into a stalled buffer, then hunt clears overflow
    rdy = 0;
    send_word(SYNC, 16);
    send_word(16'h11, 8);
    send_word(16'h22, 8);
    send_word(16'h33, 8);
    idle(2);
    cyc(1'b0, 0, 1'b1);
    rdy = 1;
    idle(4);

    // Push and pop together on a full buffer
    rdy = 0;
    send_word(SYNC, 16);
    send_word(16'h44, 8);
    send_word(16'h55, 8);
    send_word(16'h33, 7);
    rdy = 1;
    send_bit(1'b0);
    cyc(1'b0, 0, 1'b1);
    idle(4);

    // Asynchronous reset mid-frame with three bits assembled
    send_word(SYNC, 16);
    send_word(16'h5, 3);
    #4;
    rst = 1'b0;
    avg_valid = 0; hunt = 0; byte_ready = 0; average = 32'd0;
    model_reset();
    #1;
    check("async_reset", {2'd0, byte_out, byte_valid, sync_found, inverted, frame_active,
                          frame_done, overflow, erasures}, 32'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    send_word(16'hC3, 8);
    send_word(SYNC, 16);
    send_word(16'h77, 8);
    cyc(1'b0, 0, 1'b1);
    idle(3);

    // Randomized frames with noise, stalls, gaps and occasional hunt
    for (int f = 0; f < 40; f++) begin
      logic [15:0] w;
      w = ($urandom_range(0, 1) != 0) ? ~SYNC : SYNC;
      for (int i = 0; i < int'($urandom_range(0, 20)); i++) rand_bit(1'($urandom), 1'b0);
      for (int i = 15; i >= 0; i--) rand_bit(w[i], 1'b1);
      for (int i = 0; i < FB * 8; i++) rand_bit(1'($urandom), 1'b0);
    end

    rdy = 1;
    idle(10);
    repeat (2) @(posedge clk);
    #2;
    check("drain", exp_bytes.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/avg_bit_slicer.md
# avg_bit_slicer

Downstream stage of the IQ averager. It takes each signed 32-bit `average` result on its `valid` strobe and slices it to a hard bit, using hysteresis. It then hunts for a 16-bit sync word in either polarity, packs the following data bits MSB-first into bytes, and hands the bytes to the processor-side logic through a 2-entry valid/ready buffer.

## Interface
Parameters:
- `SYNC_WORD`, default 16'h2DD4: frame sync pattern. Its bitwise inverse is also accepted.
- `FRAME_BYTES`, default 8: data bytes per frame after sync. Legal range 1..255.
- `HYST`, default 256: decision dead-band half-width. Positive, less than 2^30.

Ports:
- `clk`, in, 1: sole clock. All logic is on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `average`, in, 32: signed averaged amplitude from the averager.
- `avg_valid`, in, 1: one-cycle strobe qualifying `average`. There is no backpressure to upstream.
- `hunt`, in, 1: synchronous request to return to HUNT and clear sticky flags.
- `byte_out`, out, 8: head of the output buffer.
- `byte_valid`, out, 1: the output buffer is non-empty.
- `byte_ready`, in, 1: consumer accepts `byte_out` when `byte_valid && byte_ready`.
- `sync_found`, out, 1: one-cycle pulse when sync is detected.
- `inverted`, out, 1: the current frame was synced on ~SYNC_WORD.
- `frame_active`, out, 1: high while in the DATA state.
- `frame_done`, out, 1: one-cycle pulse when the last byte of a frame is pushed.
- `overflow`, out, 1: sticky. A completed byte was dropped because the buffer was full.
- `erasures`, out, 16: saturating count of dead-band decisions since the last sync.

## Operation
Decision, evaluated on each `avg_valid`:
- If `$signed(average) > HYST`, the raw bit is 1.
- If `$signed(average) < -HYST`, the raw bit is 0.
- Otherwise the raw bit repeats the previous raw bit, and `erasures` increments. It saturates at 16'hFFFF.
- The previous raw bit resets to 0.
- The data bit is the raw bit XOR `inverted`.

States: HUNT, DATA.
- HUNT:
  - The 16-bit shift register shifts in the raw bit, MSB first.
  - Match is tested on the post-shift value, computed combinationally from the register and the new bit.
  - A match with SYNC_WORD causes: transition to DATA, `inverted`=0, a `sync_found` pulse, and `erasures` cleared to 0.
  - A match with ~SYNC_WORD does the same with `inverted`=1.
- DATA:
  - Data bits shift into an 8-bit assembler.
  - On the 8th bit the byte is pushed to the buffer and the byte counter increments.
  - On the FRAME_BYTES-th push: pulse `frame_done`, go to HUNT, and clear the shift register to 0.
  - The byte counts toward the frame even if it is dropped.
- `hunt` has priority over `avg_valid` in the same cycle. It forces HUNT and clears: shift register, bit counter, byte counter, `overflow`, `erasures`, `inverted`. The buffer is not flushed.

Output buffer:
- 2-entry FIFO.
- Push when full and no pop in the same cycle: the byte is dropped and `overflow` is set.
- Push and pop in the same cycle while full: the push is accepted and `overflow` is unchanged.
- Pop when empty: no effect.

Reset (asynchronous, any state, mid-frame included):
- State is HUNT.
- All registers and counters are 0, and the buffer is empty.
- Every output is 0: `byte_out`, `byte_valid`, `sync_found`, `inverted`, `frame_active`, `frame_done`, `overflow`, `erasures`.

## Timing
- All outputs are registered.
- Sync detect:
  - `sync_found` and `frame_active` rise on the cycle after the `avg_valid` cycle carrying the 16th sync bit.
  - `sync_found` lasts one cycle.
- Byte latency:
  - `byte_valid` rises one cycle after the `avg_valid` cycle carrying the 8th bit of the byte, when the buffer was empty.
  - `byte_out` is stable while `byte_valid && !byte_ready`.
- `frame_done`:
  - Asserts in the same cycle that the last byte's `byte_valid`/buffer write takes effect.
  - `frame_active` falls in that same cycle.
- Throughput: one bit per `avg_valid`. Back-to-back strobes, one per cycle, must be supported.

## Structure
- Package `avg_slicer_pkg`:
  - state enum {HUNT, DATA};
  - default SYNC_WORD;
  - width constants for `average` (32), sync (16) and `erasures` (16).
- Sub-module `byte_fifo2`: the 2-entry, 8-bit, valid/ready FIFO, with a `full` flag and a push-when-full drop indication.

## Test plan
- Reset: drive `rst`=0 mid-DATA with 3 bits assembled → all outputs go 0 asynchronously. After release, the first byte requires a fresh sync.
- Normal frame:
  - Stimulus: `average`=1080 for 1-bits and -1900 for 0-bits encoding 16'h2DD4, then bytes 8'hA5,8'h3C,…, 8 bytes total; `byte_ready`=1.
  - Required: `sync_found` pulse, `inverted`=0, bytes out in order, `frame_done` after the 8th byte, return to HUNT.
- Inverted sync: send ~16'h2DD4 then the raw bit pattern 8'h5A → `inverted`=1, `byte_out`=8'hA5.
- Dead-band:
  - Stimulus: after sync, samples 1080, 100, -100, -1960 as the first four bits.
  - Required: bits 1,1,1,0, and `erasures`=2.
- Backpressure: hold `byte_ready`=0 for 3 bytes → bytes 1–2 retained, byte 3 dropped, `overflow`=1. Then assert `hunt` → `overflow`=0, state HUNT.
- Simultaneous push/pop on a full buffer with `byte_ready`=1 → no drop, `overflow` stays 0, order preserved.
